rf_debug_access: RTL
====================

// Module: rf_debug_access
// PURPOSE
// Debug-side initiator for the integer register file: turns one command at a time into a
//   register read or write, and returns one response per command.
// Before any access it halts the core and waits for the core to confirm the halt.
//   It then takes over the register-file ports for exactly one cycle.
// Sits between the debug transport and the register-file port mux.
//   The top level routes the RF write port and read port 1 to this block while rf_sel_o=1.
// PARAMETERS
// HALT_TIMEOUT  255  maximum cycles to wait for core_halted_i; 0 disables the timeout
// PORTS
// clk_i            in   1   clock, all state updates on rising edge
// rst_ni           in   1   asynchronous active-low reset
// cmd_valid_i      in   1   command offered
// cmd_ready_o      out  1   command accepted when cmd_valid_i & cmd_ready_o
// cmd_write_i      in   1   1 = write register, 0 = read register
// cmd_addr_i       in   5   register index x0..x31
// cmd_wdata_i      in   32  write data
// rsp_valid_o      out  1   response available
// rsp_ready_i      in   1   response consumed when rsp_valid_o & rsp_ready_i
// rsp_rdata_o      out  32  read data; 0 for writes and for errors
// rsp_err_o        out  1   1 = core did not halt within HALT_TIMEOUT, no RF access done
// core_halt_req_o  out  1   request the core to stall and drain writeback
// core_halted_i    in   1   core is stalled and will not write the RF
// rf_sel_o         out  1   mux select: RF write port and read port 1 owned by this block
// rf_we_o          out  1   RF write enable
// rf_waddr_o       out  5   RF write address
// rf_wdata_o       out  32  RF write data
// rf_raddr_o       out  5   RF read address (port 1)
// rf_rdata_i       in   32  RF read data (port 1); combinational from rf_raddr_o
// BEHAVIOUR
// - States: IDLE, HALT, ACCESS, RESP. Reset (rst_ni=0, asynchronous) forces IDLE.
//   - Reset clears the latched command, the timeout counter and all outputs to 0.
//   - cmd_ready_o is 0 while in reset.
//   - Reset mid-operation abandons the command, drops core_halt_req_o and sends no response.
// - IDLE: cmd_ready_o=1, all other outputs 0.
//   - On accept, latch write/addr/wdata, clear the counter and go to HALT.
// - HALT: core_halt_req_o=1.
//   - If core_halted_i=1 when sampled, go to ACCESS.
//   - Otherwise increment the counter.
//   - If HALT_TIMEOUT!=0 and the counter reaches HALT_TIMEOUT-1 with no halt: go to RESP with err=1 and rdata=0.
// - ACCESS (exactly 1 cycle): core_halt_req_o=1, rf_sel_o=1.
//   - Write: rf_we_o=1 with rf_waddr_o/rf_wdata_o from the latched command.
//   - Write to x0: rf_we_o stays 0; the response is still err=0.
//   - Read: rf_raddr_o=addr; rf_rdata_i is captured into rsp_rdata_o at the end of this cycle.
//   - Read of x0 returns 0.
//   - Go to RESP.
// - RESP: rsp_valid_o=1, with rsp_rdata_o and rsp_err_o held stable until rsp_ready_i=1.
//   - Go to IDLE on the same edge that rsp_ready_i=1 is sampled.
//   - core_halt_req_o, rf_sel_o and rf_we_o are all 0 in RESP.
// - Latency: accept at edge T with core_halted_i=1 -> ACCESS at T+1..T+2 -> rsp_valid_o=1 from T+2.
//   - Throughput: at most one command in flight; cmd_ready_o=0 outside IDLE.
// - rf_sel_o / rf_we_o are never 1 outside ACCESS.
//   - This guarantees no write collides with core writeback.
// - core_halted_i dropping during ACCESS is ignored; the access completes.
// - cmd_* inputs changing after accept have no effect.
// TESTING
// 1. Halt immediate: write x5=0xDEADBEEF, core_halted_i=1
//    -> exactly one cycle with rf_we_o=1, waddr=5, wdata=0xDEADBEEF; then rsp_valid_o, err=0, rdata=0.
// 2. Read x5 after test 1, with a behavioural RF model
//    -> rsp_rdata_o=0xDEADBEEF; rsp_valid_o appears 2 cycles after accept.
// 3. Write x0=0x1234 -> rf_we_o never asserted; a following read of x0 -> rdata=0, err=0.
// 4. HALT_TIMEOUT=4, core_halted_i held 0
//    -> rsp_valid_o with err=1, rdata=0 after 4 cycles in HALT; rf_sel_o never 1.
// 5. Backpressure: rsp_ready_i=0 for 10 cycles in RESP
//    -> rsp_* stable and cmd_ready_o=0 throughout; IDLE the cycle after ready.
// 6. Reset asserted while in HALT
//    -> core_halt_req_o=0 immediately, IDLE, no response; the next command completes normally.

Source files
------------

// File: rtl/rf_debug_access.sv
// Debug initiator for the integer RF: halts the core, owns the RF ports for one cycle, returns one response per command.
// Response 2 cycles after accept when the core is already halted; one command in flight, held in RESP until rsp_ready_i.
module rf_debug_access #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        core_halt_req_o,
    input  logic        core_halted_i,
    output logic        rf_sel_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i
);

    localparam int          CNT_W   = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);
    localparam bit          TO_EN   = (HALT_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = (HALT_TIMEOUT == 0) ? '0 : CNT_W'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, HALT, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [4:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              timeout;

    assign timeout = TO_EN && (cnt_q == TO_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cmd_valid_i) state_d = HALT;
            HALT:    if (core_halted_i) state_d = ACCESS;
                     else if (timeout)  state_d = RESP;
            ACCESS:  state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                write_d = cmd_write_i;
                addr_d  = cmd_addr_i;
                wdata_d = cmd_wdata_i;
                cnt_d   = '0;
            end
            HALT: if (!core_halted_i) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ACCESS: begin
                err_d   = 1'b0;
                // x0 is forced to zero here rather than trusting the RF port
                rdata_d = (!write_q && addr_q != 5'd0) ? rf_rdata_i : 32'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cmd_ready_o     = rst_ni && (state_q == IDLE);
        rsp_valid_o     = (state_q == RESP);
        rsp_rdata_o     = (state_q == RESP) ? rdata_q : 32'd0;
        rsp_err_o       = (state_q == RESP) && err_q;
        core_halt_req_o = (state_q == HALT) || (state_q == ACCESS);
        rf_sel_o        = (state_q == ACCESS);
        rf_we_o         = (state_q == ACCESS) && write_q && (addr_q != 5'd0);
        rf_waddr_o      = ((state_q == ACCESS) && write_q) ? addr_q : 5'd0;
        rf_wdata_o      = ((state_q == ACCESS) && write_q) ? wdata_q : 32'd0;
        rf_raddr_o      = ((state_q == ACCESS) && !write_q) ? addr_q : 5'd0;
    end

endmodule
